// File: rtl/int_gateway_arb.sv
// Interrupt gateway and fixed-priority arbiter.
//
// Each source has a three-state gateway (idle / pending / inflight). A high
// level in idle captures a request. A claim of the advertised ID moves that
// source to inflight. A matching completion returns it to idle. Among pending
// and enabled sources the lowest index wins. The winner is registered onto
// io_irq_valid / io_irq_id.
//
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   io_int_in[NINT]     synchronized level interrupts, bit i is ID i+1
//   io_enable[NINT]     per-source arbitration enable
//   io_irq_valid/id     registered winner; id is 0 when not valid
//   io_claim            claim of the currently advertised ID
//   io_complete_valid   completion strobe, with io_complete_id
//   io_pending[NINT]    per-source pending status, decoded from state
module int_gateway_arb #(
  parameter int unsigned NINT = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NINT-1:0] io_int_in,
  input  logic [NINT-1:0] io_enable,
  output logic            io_irq_valid,
  output logic [IDW-1:0]  io_irq_id,
  input  logic            io_claim,
  input  logic            io_complete_valid,
  input  logic [IDW-1:0]  io_complete_id,
  output logic [NINT-1:0] io_pending
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPending  = 2'd1,
    StInflight = 2'd2
  } gw_state_e;

  gw_state_e        state_q [NINT];
  gw_state_e        state_d [NINT];
  logic             irq_valid_q, irq_valid_d;
  logic [IDW-1:0]   irq_id_q, irq_id_d;

  // Per-source gateway transitions. A claim only counts against the ID that is
  // currently advertised. A repeated claim therefore finds the source already
  // inflight and has no effect. Completion IDs of 0 or above NINT match no
  // source.
  always_comb begin
    for (int i = 0; i < int'(NINT); i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (io_int_in[i]) state_d[i] = StPending;
        end
        StPending: begin
          if (io_claim && irq_valid_q && (irq_id_q == IDW'(i + 1))) state_d[i] = StInflight;
        end
        StInflight: begin
          if (io_complete_valid && (io_complete_id == IDW'(i + 1))) state_d[i] = StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Arbitration works on the registered pending state. Scanning from the top
  // down lets the lowest index overwrite the others, so it wins.
  always_comb begin
    irq_valid_d = 1'b0;
    irq_id_d    = '0;
    for (int i = int'(NINT) - 1; i >= 0; i--) begin
      if ((state_q[i] == StPending) && io_enable[i]) begin
        irq_valid_d = 1'b1;
        irq_id_d    = IDW'(i + 1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NINT); i++) state_q[i] <= StIdle;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      for (int i = 0; i < int'(NINT); i++) state_q[i] <= state_d[i];
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NINT); i++) io_pending[i] = (state_q[i] == StPending);
  end

  assign io_irq_valid = irq_valid_q;
  assign io_irq_id    = irq_id_q;

endmodule
